maxnet_driver: RTL and testbench

- Initiator-side sequencer for the Maxnet competitive network. Maxnet is the responder: it takes a one-cycle start, four IEEE-754 single-precision inputs X1..X4, and returns done with a result.
- The block buffers up to DEPTH input vector sets written by a host. On go, it issues them to Maxnet one at a time and streams each captured result back to the host.
- It replaces the hand-written start pulse and fixed operands currently used in simulation. It also serves as the in-system front end for batch classification.

---
 rtl/maxnet_driver.sv | 148 ++++++++++++++
 tb/tb_maxnet_driver.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_driver.sv
// maxnet_driver: buffers host vector sets and runs them through
// the Maxnet responder one at a time, streaming each result back.
module maxnet_driver #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [4*W-1:0]             load_vec,
  input  logic                       go,
  input  logic                       mx_done,
  input  logic [W-1:0]               mx_result,
  output logic                       mx_start,
  output logic [W-1:0]               mx_x1,
  output logic [W-1:0]               mx_x2,
  output logic [W-1:0]               mx_x3,
  output logic [W-1:0]               mx_x4,
  output logic                       res_valid,
  output logic [W-1:0]               res_data,
  output logic [$clog2(DEPTH)-1:0]   res_index,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       finished,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, FINISH
  } state_t;

  state_t         state;
  logic [4*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_nxt;
  logic [TW-1:0]  wcnt;
  logic           armed;
  logic           wr_en;
  logic [CW-1:0]  cnt_upd;
  logic [4*W-1:0] first_vec;
  logic [4*W-1:0] next_vec;
  logic           last;
  logic           hit;
  logic           tmo;

  assign wr_en   = (state == IDLE) && load_en
                 && (count < CW'(DEPTH));
  assign cnt_upd = count + CW'(wr_en);
  // a load coinciding with go may be filling slot 0
  assign first_vec = (wr_en && wr_ptr == '0)
                   ? load_vec : mem[0];
  assign rd_nxt   = rd_ptr + AW'(1);
  assign next_vec = mem[rd_nxt];
  assign last     = (CW'(rd_ptr) + CW'(1)) == count;
  assign hit      = armed && mx_done;
  assign tmo      = wcnt == TW'(TIMEOUT-1);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= load_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wcnt        <= '0;
      armed       <= 1'b0;
      mx_start    <= 1'b0;
      mx_x1       <= '0;
      mx_x2       <= '0;
      mx_x3       <= '0;
      mx_x4       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_index   <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mx_start  <= 1'b0;
      res_valid <= 1'b0;
      finished  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= cnt_upd;
          end
          if (go) begin
            busy <= 1'b1;
            if (cnt_upd != '0) begin
              timeout_err <= 1'b0;
              rd_ptr      <= '0;
              mx_start    <= 1'b1;
              {mx_x4, mx_x3, mx_x2, mx_x1} <= first_vec;
              state       <= ISSUE;
            end else begin
              state <= FINISH;
            end
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          armed <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + TW'(1);
          // a done still high from the last run must drop first
          if (!mx_done) armed <= 1'b1;
          if (hit) begin
            res_valid <= 1'b1;
            res_data  <= mx_result;
            res_index <= rd_ptr;
            if (last) begin
              state <= FINISH;
            end else begin
              rd_ptr   <= rd_nxt;
              mx_start <= 1'b1;
              {mx_x4, mx_x3, mx_x2, mx_x1} <= next_vec;
              state    <= ISSUE;
            end
          end else if (tmo) begin
            timeout_err <= 1'b1;
            state       <= FINISH;
          end
        end
        FINISH: begin
          finished <= 1'b1;
          count    <= '0;
          wr_ptr   <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_driver.sv
// Bench for maxnet_driver: responder model plus a result
// scoreboard fed at load time and drained on res_valid.
module tb_maxnet_driver;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_en = 1'b0;
  logic [127:0] load_vec = '0;
  logic         go = 1'b0;
  logic         mx_done = 1'b0;
  logic [31:0]  mx_result = '0;
  logic         mx_start;
  logic [31:0]  mx_x1, mx_x2, mx_x3, mx_x4;
  logic         res_valid;
  logic [31:0]  res_data;
  logic [1:0]   res_index;
  logic [2:0]   count;
  logic         busy;
  logic         finished;
  logic         timeout_err;

  int tests = 0;
  int fails = 0;
  int rmode = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  i;
  } exp_t;
  exp_t sb[$];

  maxnet_driver #(.W(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_vec(load_vec), .go(go),
    .mx_done(mx_done), .mx_result(mx_result),
    .mx_start(mx_start),
    .mx_x1(mx_x1), .mx_x2(mx_x2),
    .mx_x3(mx_x3), .mx_x4(mx_x4),
    .res_valid(res_valid), .res_data(res_data),
    .res_index(res_index), .count(count),
    .busy(busy), .finished(finished),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmax(
    input logic [127:0] v);
    logic [31:0] m;
    m = v[31:0];
    for (int i = 1; i < 4; i++)
      if (v[32*i +: 32] > m) m = v[32*i +: 32];
    return m;
  endfunction

  // responder: 0 normal, 1 stale done, 2 never done
  int          rk = 0;
  bit          rpend = 0;
  bit          rstale = 0;
  logic [31:0] rres = '0;
  always @(posedge clk) begin
    if (mx_start === 1'b1) begin
      rpend  = 1;
      rk     = 0;
      rres   = fmax({mx_x4, mx_x3, mx_x2, mx_x1});
      rstale = (rmode == 1) && mx_done;
      if (!rstale) mx_done <= 1'b0;
    end else if (rpend) begin
      rk++;
      if (rmode == 2) begin
      end else if (rstale && rk < 3) begin
      end else if (rstale && rk < 6) begin
        mx_done <= 1'b0;
      end else if (!rstale && rk < 5) begin
      end else begin
        mx_done   <= 1'b1;
        mx_result <= rres;
        rpend = 0;
      end
    end
  end

  logic [127:0] snap;
  bit           snap_ok = 0;
  bit           unstable = 0;
  always @(negedge clk) begin
    exp_t e;
    if (res_valid === 1'b1) begin
      tests++;
      if (unstable) begin
        fails++;
        $display("FAIL operand_stable: mx_x changed in WAIT");
      end
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: data %h idx %0d, none expected",
                 res_data, res_index);
      end else begin
        e = sb.pop_front();
        if (res_data !== e.d || res_index !== e.i) begin
          fails++;
          $display("FAIL sb_result: got %h idx %0d, want %h idx %0d",
                   res_data, res_index, e.d, e.i);
        end
      end
    end
    if (mx_start === 1'b1) begin
      snap     = {mx_x4, mx_x3, mx_x2, mx_x1};
      snap_ok  = 1;
      unstable = 0;
    end else if (busy === 1'b1 && snap_ok &&
                 {mx_x4, mx_x3, mx_x2, mx_x1} !== snap) begin
      unstable = 1;
    end
  end

  localparam logic [127:0] VS =
    {32'h3F4CCCCD, 32'h3F19999A, 32'h3ECCCCCD, 32'h3E4CCCCD};
  localparam logic [127:0] V0 =
    {32'h40400000, 32'h40000000, 32'h3F800000, 32'h40A00000};
  localparam logic [127:0] V1 =
    {32'h3F800000, 32'h3F000000, 32'h41200000, 32'h40000000};
  localparam logic [127:0] V2 =
    {32'h3E800000, 32'h42C80000, 32'h3F800000, 32'h3F000000};
  localparam logic [127:0] V3 =
    {32'h43480000, 32'h40000000, 32'h41000000, 32'h3F800000};
  localparam logic [127:0] V5 =
    {32'h44000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] v,
                         input logic [31:0] mx,
                         input int idx, input bit push);
    exp_t e;
    load_en  = 1'b1;
    load_vec = v;
    tick();
    load_en  = 1'b0;
    if (push) begin
      e.d = mx;
      e.i = 2'(idx);
      sb.push_back(e);
    end
  endtask

  task automatic run_go(input int bound,
                        output int starts, output int st_first,
                        output int rvs, output int rv_last,
                        output int fin_at);
    go = 1'b1;
    tick();
    go = 1'b0;
    starts = 0; st_first = -1;
    rvs = 0; rv_last = -1; fin_at = -1;
    for (int c = 1; c <= bound && fin_at < 0; c++) begin
      @(negedge clk);
      if (mx_start === 1'b1) begin
        starts++;
        if (st_first < 0) st_first = c;
      end
      if (res_valid === 1'b1) begin
        rvs++;
        rv_last = c;
      end
      if (finished === 1'b1) fin_at = c;
    end
    if (fin_at < 0) begin
      tests++; fails++;
      $display("FAIL run_finish: no finished within %0d cycles", bound);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({mx_start, res_valid, finished, timeout_err, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {mx_start, res_valid, finished, timeout_err, busy});
    end
    tests++;
    if (count !== 3'd0 || res_index !== 2'd0) begin
      fails++;
      $display("FAIL reset_count: count %0d idx %0d want 0 0",
               count, res_index);
    end
    tests++;
    if ({mx_x1, mx_x2, mx_x3, mx_x4, res_data} !== 160'd0) begin
      fails++;
      $display("FAIL reset_data: operands/res_data not zero, res_data %h",
               res_data);
    end
  endtask

  task automatic test_single;
    int st, sf, rv, rl, fa;
    do_load(VS, 32'h3F4CCCCD, 0, 1);
    run_go(60, st, sf, rv, rl, fa);
    tests++;
    if (st !== 1 || sf !== 1) begin
      fails++;
      $display("FAIL single_start: %0d pulses first at %0d, want 1 at 1",
               st, sf);
    end
    tests++;
    if (rv !== 1 || fa !== rl + 1) begin
      fails++;
      $display("FAIL single_finish: rv %0d at %0d fin at %0d, want 1 and fin=rv+1",
               rv, rl, fa);
    end
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL single_count: got %0d want 0", count);
    end
  endtask

  task automatic test_full_batch;
    int st, sf, rv, rl, fa, extra;
    do_load(V0, 32'h40A00000, 0, 1);
    do_load(V1, 32'h41200000, 1, 1);
    do_load(V2, 32'h42C80000, 2, 1);
    do_load(V3, 32'h43480000, 3, 1);
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL batch_count: got %0d want 4", count);
    end
    run_go(200, st, sf, rv, rl, fa);
    tests++;
    if (st !== 4 || rv !== 4) begin
      fails++;
      $display("FAIL batch_pulses: starts %0d results %0d want 4 4", st, rv);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (finished === 1'b1) extra++;
    end
    tests++;
    if (extra !== 0 || sb.size() !== 0) begin
      fails++;
      $display("FAIL batch_tail: extra finished %0d pending %0d want 0 0",
               extra, sb.size());
    end
  endtask

  task automatic test_overflow;
    int st, sf, rv, rl, fa;
    do_load(V3, 32'h43480000, 0, 1);
    do_load(V2, 32'h42C80000, 1, 1);
    do_load(V1, 32'h41200000, 2, 1);
    do_load(V0, 32'h40A00000, 3, 1);
    do_load(V5, 32'h44000000, 0, 0);
    @(negedge clk);
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL overflow_count: got %0d want 4", count);
    end
    run_go(200, st, sf, rv, rl, fa);
    tests++;
    if (rv !== 4 || sb.size() !== 0) begin
      fails++;
      $display("FAIL overflow_results: got %0d pending %0d want 4 0",
               rv, sb.size());
    end
  endtask

  task automatic test_empty_go;
    int st, sf, rv, rl, fa;
    run_go(5, st, sf, rv, rl, fa);
    tests++;
    if (st !== 0 || rv !== 0 || fa < 1 || fa > 2) begin
      fails++;
      $display("FAIL empty_go: starts %0d rv %0d fin at %0d want 0 0 1..2",
               st, rv, fa);
    end
  endtask

  task automatic test_stale;
    int st, sf, rv, rl, fa;
    rmode = 1;
    do_load(V1, 32'h41200000, 0, 1);
    do_load(V2, 32'h42C80000, 1, 1);
    run_go(100, st, sf, rv, rl, fa);
    tests++;
    if (rv !== 2 || sb.size() !== 0) begin
      fails++;
      $display("FAIL stale_results: got %0d pending %0d want 2 0",
               rv, sb.size());
    end
    rmode = 0;
  endtask

  task automatic test_timeout;
    int st, sf, rv, rl, fa;
    bit seen;
    rmode = 2;
    do_load(V0, 32'h40A00000, 0, 0);
    run_go(60, st, sf, rv, rl, fa);
    tests++;
    if (timeout_err !== 1'b1 || rv !== 0 || st !== 1) begin
      fails++;
      $display("FAIL timeout_abort: err %b rv %0d starts %0d want 1 0 1",
               timeout_err, rv, st);
    end
    rmode = 0;
    do_load(V3, 32'h43480000, 0, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b want 0", timeout_err);
    end
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (finished === 1'b1) seen = 1;
    end
    tests++;
    if (!seen || sb.size() !== 0) begin
      fails++;
      $display("FAIL timeout_rerun: finished %b pending %0d want 1 0",
               seen, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int st, sf, rv, rl, fa, bad;
    rmode = 2;
    do_load(V2, 32'h42C80000, 0, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_en = 1'b1;
    load_vec = V1;
    @(negedge clk);
    tests++;
    if ({mx_start, res_valid, finished, timeout_err, busy} !== 5'b0 ||
        count !== 3'd0 || res_data !== 32'd0 ||
        {mx_x1, mx_x2, mx_x3, mx_x4} !== 128'd0) begin
      fails++;
      $display("FAIL midreset_outputs: flags %b count %0d res %h want 0",
               {mx_start, res_valid, finished, timeout_err, busy},
               count, res_data);
    end
    tick();
    load_en = 1'b0;
    begin
      exp_t e;
      e.d = 32'h41200000;
      e.i = 2'd0;
      sb.push_back(e);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (finished === 1'b1 || res_valid === 1'b1) bad++;
    end
    tests++;
    if (bad !== 0 || count !== 3'd1) begin
      fails++;
      $display("FAIL midreset_after: stray pulses %0d count %0d want 0 1",
               bad, count);
    end
    rmode = 0;
    run_go(60, st, sf, rv, rl, fa);
    tests++;
    if (rv !== 1 || sb.size() !== 0) begin
      fails++;
      $display("FAIL midreset_rerun: got %0d pending %0d want 1 0",
               rv, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_batch();
    test_overflow();
    test_empty_go();
    test_stale();
    test_timeout();
    test_reset_mid();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

endmodule
